// File: rtl/riscv_prog_loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_loader_pkg : shared types and constants for the program loader
// Rev 1.0
// ---------------------------------------------------------------------------
package riscv_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

  typedef logic [8*LEN_BYTES-1:0] len_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loader_state_t;

endpackage : riscv_loader_pkg
`default_nettype wire

// File: rtl/riscv_prog_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_prog_loader_if : byte-stream input and imem write port of the loader
// Rev 1.0
// ---------------------------------------------------------------------------
interface riscv_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // master: host link / memory side; slave: the loader itself
  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface : riscv_prog_loader_if
`default_nettype wire

// File: rtl/riscv_prog_loader_word_asm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// loader_word_asm : little-endian byte-to-word assembler
// Rev 1.0
// ---------------------------------------------------------------------------
module loader_word_asm
  import riscv_loader_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        clr,
  input  wire logic [7:0]  byte_in,
  input  wire logic        byte_en,
  output logic      [31:0] word,
  output logic             word_valid
);

  logic [31:0] r_sr;
  logic [1:0]  r_idx;

  // Word is presented combinationally with the final byte so the write can
  // be registered on the very edge that accepts it.
  assign word       = {byte_in, r_sr[31:8]};
  assign word_valid = byte_en && (r_idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_sr  <= '0;
      r_idx <= '0;
    end else if (byte_en) begin
      r_sr  <= {byte_in, r_sr[31:8]};
      r_idx <= r_idx + 2'd1;
    end
  end

endmodule : loader_word_asm
`default_nettype wire

// File: rtl/riscv_prog_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_prog_loader : streams a length-prefixed image into imem, holds the
// core in reset until done. Option macro: RISCV_LOADER_CHECKSUM_EN. Rev 1.0
// ---------------------------------------------------------------------------
module riscv_prog_loader
  import riscv_loader_pkg::*;
#(
  parameter int PROG_SIZE = 648,
  parameter int ADDR_W    = $clog2(PROG_SIZE)
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            start,
  riscv_prog_loader_if.slave   bus,
  output logic                 core_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  loader_state_t     r_state;
  logic              r_in_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_core_rst;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [ADDR_W:0]   r_wcnt;
  logic [7:0]        r_len_lo;
  len_t              r_len;

  logic              w_xfer;
  logic              w_start_ok;
  len_t              w_len;
  logic [31:0]       w_word;
  logic              w_word_valid;
  logic              w_last_word;

  assign w_xfer      = bus.in_valid && r_in_ready;
  assign w_start_ok  = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_len       = {bus.in_data, r_len_lo};
  assign w_last_word = (len_t'(r_wcnt) == r_len - len_t'(1));

  loader_word_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (w_start_ok),
    .byte_in    (bus.in_data),
    .byte_en    (w_xfer && (r_state == DATA)),
    .word       (w_word),
    .word_valid (w_word_valid)
  );

`ifdef RISCV_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_csum <= '0;
    end else if (w_xfer && (r_state == DATA)) begin
      r_csum <= r_csum ^ bus.in_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_core_rst <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_wcnt     <= '0;
      r_len_lo   <= '0;
      r_len      <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: begin
          if (start) begin
            r_state    <= LEN_LO;
            r_in_ready <= 1'b1;
            r_core_rst <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_wcnt     <= '0;
          end
        end
        LEN_LO: begin
          if (w_xfer) begin
            r_len_lo <= bus.in_data;
            r_state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (w_xfer) begin
            r_len <= w_len;
            if (w_len == '0 || w_len > len_t'(PROG_SIZE)) begin
              r_state    <= ERR;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_word_valid) begin
            r_we    <= 1'b1;
            r_addr  <= r_wcnt[ADDR_W-1:0];
            r_wdata <= w_word;
            r_wcnt  <= r_wcnt + 1'b1;
            if (w_last_word) begin
`ifdef RISCV_LOADER_CHECKSUM_EN
              r_state    <= CHK;
`else
              // Core leaves reset on the same edge the final write is issued
              r_state    <= DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_core_rst <= 1'b0;
`endif
            end
          end
        end
`ifdef RISCV_LOADER_CHECKSUM_EN
        CHK: begin
          if (w_xfer) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (bus.in_data == r_csum) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_core_rst <= 1'b0;
            end else begin
              r_state <= ERR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_core_rst <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign core_rst       = r_core_rst;
  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;

endmodule : riscv_prog_loader
`default_nettype wire

// File: tb/tb_riscv_prog_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_riscv_prog_loader : directed, table-driven bench for riscv_prog_loader
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_riscv_prog_loader;

  localparam int PROG_SIZE = 648;
  localparam int ADDR_W    = 10;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic core_rst, busy, done, error;

  int checks = 0;
  int errors = 0;

  riscv_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  riscv_prog_loader #(.PROG_SIZE(PROG_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .core_rst (core_rst),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Write log, sampled mid-cycle
  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];
  logic              wdone[$];
  logic              wcrst[$];

  always @(negedge clk) begin
    if (bus.imem_we) begin
      wa.push_back(bus.imem_addr);
      wd.push_back(bus.imem_wdata);
      wdone.push_back(done);
      wcrst.push_back(core_rst);
    end
  end

  typedef struct {
    logic [15:0]       len;
    int                nw;
    logic [2:0][31:0]  w;
    bit                bad_csum;
    bit                exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wdone.delete(); wcrst.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got in_ready=0 expected 1 byte %h", b);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] len, input int nw,
                            input logic [2:0][31:0] w, input bit bad, input bit rnd);
    logic [7:0] x;
    logic [7:0] d;
    x = 8'h00;
    pulse_start();
    send_byte(len[7:0], 0);
    send_byte(len[15:8], 0);
    for (int i = 0; i < nw; i++) begin
      for (int b = 0; b < 4; b++) begin
        d = w[i][8*b +: 8];
        x ^= d;
        send_byte(d, rnd ? int'($urandom_range(0, 5)) : 0);
      end
    end
`ifdef RISCV_LOADER_CHECKSUM_EN
    if (nw > 0) send_byte(bad ? (x ^ 8'h44) : x, 0);
`else
    if (bad) x = 8'h00;
`endif
    repeat (3) @(negedge clk);
  endtask

  vec_t vecs[8];
  int   nvec;

  initial begin
    logic [7:0] x;
    logic [7:0] d;
    logic [31:0] word;
    int seq_bad;
    int exp_nwr;
    bit len_bad;

    rst = 1'b1;
    start = 1'b0;
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;

    vecs[0] = '{len: 16'd2,   nw: 2, w: {32'h0, 32'h00500593, 32'h00A00513}, bad_csum: 1'b0, exp_err: 1'b0};
    vecs[1] = '{len: 16'd649, nw: 0, w: '0, bad_csum: 1'b0, exp_err: 1'b1};
    vecs[2] = '{len: 16'd1,   nw: 1, w: {32'h0, 32'h0, 32'hDEADBEEF}, bad_csum: 1'b0, exp_err: 1'b0};
    vecs[3] = '{len: 16'd0,   nw: 0, w: '0, bad_csum: 1'b0, exp_err: 1'b1};
    vecs[4] = '{len: 16'd3,   nw: 3, w: {32'h99AABBCC, 32'h55667788, 32'h11223344}, bad_csum: 1'b0, exp_err: 1'b0};
    vecs[5] = '{len: 16'hFFFF, nw: 0, w: '0, bad_csum: 1'b0, exp_err: 1'b1};
    nvec = 6;
`ifdef RISCV_LOADER_CHECKSUM_EN
    vecs[6] = '{len: 16'd1, nw: 1, w: {32'h0, 32'h0, 32'h44332211}, bad_csum: 1'b0, exp_err: 1'b0};
    vecs[7] = '{len: 16'd1, nw: 1, w: {32'h0, 32'h0, 32'h44332211}, bad_csum: 1'b1, exp_err: 1'b1};
    nvec = 8;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_error",    32'(error),    32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we",       32'(bus.imem_we),  32'd0);
    chk("rst_addr",     32'(bus.imem_addr), 32'd0);
    chk("rst_wdata",    bus.imem_wdata,     32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table: each frame restarts from whatever terminal state the previous left
    for (int v = 0; v < nvec; v++) begin
      clear_log();
      send_frame(vecs[v].len, vecs[v].nw, vecs[v].w, vecs[v].bad_csum, v == 4);
      len_bad = (vecs[v].len == 16'd0) || (vecs[v].len > 16'(PROG_SIZE));
      exp_nwr = len_bad ? 0 : vecs[v].nw;
      chk($sformatf("v%0d_nwrites", v), 32'(wa.size()), 32'(exp_nwr));
      for (int i = 0; i < wa.size() && i < exp_nwr; i++) begin
        chk($sformatf("v%0d_addr%0d", v, i), 32'(wa[i]), 32'(i));
        chk($sformatf("v%0d_data%0d", v, i), wd[i], vecs[v].w[i]);
      end
`ifndef RISCV_LOADER_CHECKSUM_EN
      if (!vecs[v].exp_err && wa.size() > 0) begin
        chk($sformatf("v%0d_done_at_last_write", v), 32'(wdone[wa.size()-1]), 32'd1);
        chk($sformatf("v%0d_core_rst_at_last_write", v), 32'(wcrst[wa.size()-1]), 32'd0);
      end
`endif
      chk($sformatf("v%0d_error", v),    32'(error),    32'(vecs[v].exp_err));
      chk($sformatf("v%0d_done", v),     32'(done),     32'(!vecs[v].exp_err));
      chk($sformatf("v%0d_core_rst", v), 32'(core_rst), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_busy", v),     32'(busy),     32'd0);
      chk($sformatf("v%0d_in_ready", v), 32'(bus.in_ready), 32'd0);
    end

    // start during a load is ignored
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    pulse_start();
    chk("midstart_busy",     32'(busy),     32'd1);
    chk("midstart_core_rst", 32'(core_rst), 32'd1);
    chk("midstart_in_ready", 32'(bus.in_ready), 32'd1);
    send_byte(8'h00, 0);
    word = 32'hCAFEF00D;
    x = 8'h00;
    for (int b = 0; b < 4; b++) begin
      d = word[8*b +: 8];
      x ^= d;
      send_byte(d, 0);
    end
`ifdef RISCV_LOADER_CHECKSUM_EN
    send_byte(x, 0);
`endif
    repeat (2) @(negedge clk);
    chk("midstart_nwrites", 32'(wa.size()), 32'd1);
    if (wa.size() > 0) chk("midstart_data", wd[0], 32'hCAFEF00D);
    chk("midstart_done", 32'(done), 32'd1);

    // Reset after byte 6 of a 2-word frame
    clear_log();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    send_byte(8'hA0, 0);
    send_byte(8'h00, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_data  = 8'h55;
    bus.in_valid = 1'b1;
    repeat (6) @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_nwrites", 32'(wa.size()), 32'd1);
    if (wa.size() > 0) chk("rstmid_data0", wd[0], 32'h00A00513);
    chk("rstmid_core_rst", 32'(core_rst), 32'd1);
    chk("rstmid_done",     32'(done),     32'd0);
    chk("rstmid_busy",     32'(busy),     32'd0);
    chk("rstmid_in_ready", 32'(bus.in_ready), 32'd0);

    // Full-depth image: N == PROG_SIZE must be accepted, last write at PROG_SIZE-1
    clear_log();
    pulse_start();
    send_byte(8'(PROG_SIZE & 255), 0);
    send_byte(8'(PROG_SIZE >> 8), 0);
    x = 8'h00;
    for (int i = 0; i < PROG_SIZE; i++) begin
      word = 32'hA5000000 | 32'(i * 3);
      for (int b = 0; b < 4; b++) begin
        d = word[8*b +: 8];
        x ^= d;
        send_byte(d, 0);
      end
    end
`ifdef RISCV_LOADER_CHECKSUM_EN
    send_byte(x, 0);
`endif
    repeat (2) @(negedge clk);
    chk("full_nwrites", 32'(wa.size()), 32'(PROG_SIZE));
    seq_bad = 0;
    for (int i = 0; i < wa.size(); i++) begin
      if (wa[i] !== ADDR_W'(i) || wd[i] !== (32'hA5000000 | 32'(i * 3))) seq_bad++;
    end
    chk("full_sequence_errors", 32'(seq_bad), 32'd0);
    if (wa.size() > 0) chk("full_last_addr", 32'(wa[wa.size()-1]), 32'(PROG_SIZE - 1));
    chk("full_done",     32'(done),     32'd1);
    chk("full_error",    32'(error),    32'd0);
    chk("full_core_rst", 32'(core_rst), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_riscv_prog_loader
`default_nettype wire

// File: doc/riscv_prog_loader.md
Name: riscv_prog_loader

Overview:
- Synthesizable program loader: the write-side counterpart of the bench's instruction-memory load and data-memory readback.
- Receives a byte stream (e.g. from a UART RX) and writes 32-bit instruction words into the core's instruction memory.
- Holds the core in reset while loading; releases it once the image is complete.
- Sits between the host link and the riscv top, driving the imem write port and the core reset.

Parameters:
- PROG_SIZE, 648, instruction memory depth in 32-bit words; maximum accepted word count.
- ADDR_W, $clog2(PROG_SIZE), imem word-address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new load.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  word written.
- core_rst  out  1  reset to the riscv core; high while not DONE.
- busy  out  1  a load is in progress.
- done  out  1  level; image loaded and core released.
- error  out  1  level; load aborted.

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, busy=0, done=0, error=0. The FSM resets to IDLE.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes. Each word is assembled little-endian: the first byte goes to [7:0].
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, (CHK), DONE, ERR.
- IDLE/DONE/ERR, start=1 -> LEN_LO. On that transition: clear error/done, set core_rst=1, busy=1, word counter=0, byte index=0.
- LEN_LO: accept byte -> LEN_HI.
- LEN_HI: accept byte, then check N:
  - N==0 or N>PROG_SIZE -> ERR.
  - otherwise -> DATA.
- DATA:
  - Accept bytes, shifting them into a 32-bit assembly register and incrementing byte index modulo 4.
  - On the 4th byte: in the next cycle imem_we=1, imem_addr=word counter, imem_wdata=assembled word; then the counter increments. Write latency is 1 cycle after the 4th byte handshake.
  - After word N-1 is accepted -> DONE (or CHK when the option is enabled).
- DONE:
  - done=1, busy=0, core_rst=0.
  - core_rst deasserts in the same cycle imem_we of the last word is issued. The memory write is registered, so the core's first fetch follows the write.
- ERR: error=1, busy=0, core_rst=1. Stays until start or rst.
- in_ready=1 only in LEN_LO, LEN_HI, DATA and CHK; 0 elsewhere. in_valid outside these states is ignored.
- start during LEN_*/DATA/CHK is ignored (no restart mid-load).
- rst mid-load: immediate return to IDLE, core_rst=1, partially written memory left as is, no further writes.
- in_valid gaps of any length are allowed; there is no timeout.
- Word counter width is ADDR_W+1 so that N==PROG_SIZE does not wrap. The last write goes to address PROG_SIZE-1.

Optional Feature:
- Macro: RISCV_LOADER_CHECKSUM_EN.
- Defined: after the last data byte the FSM enters CHK and accepts one byte equal to the XOR of all 4*N data bytes.
  - Match -> DONE.
  - Mismatch -> ERR, core_rst stays 1.
  - Words already written remain in memory.
- Undefined: no CHK state; DATA goes directly to DONE.

Decomposition:
- Package riscv_loader_pkg:
  - typedef enum loader_state_t {IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR};
  - localparam BYTES_PER_WORD=4;
  - localparam LEN_BYTES=2.
- Sub-module loader_word_asm: byte-to-word assembler (shift register, 2-bit byte index, word_valid pulse). The FSM stays in riscv_prog_loader.

Test Plan:
- Reset: rst=1 for 2 cycles -> core_rst=1, done=0, error=0, in_ready=0, no imem_we.
- Nominal load: start; bytes 02 00 13 05 A0 00 93 05 50 00 -> writes 0x00A00513@0, 0x00500593@1; done=1, core_rst=0 in the cycle of the second write.
- Bad length: start; bytes 89 02 (N=649 > 648) -> error=1, core_rst=1, no imem_we. Then start + a valid 1-word frame -> done=1, error=0.
- Backpressure/gaps: random in_valid stalls of 0-5 cycles during a 3-word load -> exactly 3 writes at addresses 0,1,2 with correct data; no duplicates.
- Reset mid-load: rst asserted after byte 6 of a 2-word frame -> FSM IDLE, no further writes, core_rst=1, done=0.
- RISCV_LOADER_CHECKSUM_EN: 1-word frame 01 00 11 22 33 44 plus checksum 44 -> done=1. Same frame with checksum 00 -> error=1, core_rst=1.
